cordic_exp_ctrl: RTL

//   Control FSM sitting directly upstream of the CORDIC exponential coprocessor datapath.

---
 rtl/cordic_exp_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cordic_exp_ctrl.sv
// cordic_exp_ctrl
//   Control FSM for the CORDIC exponential coprocessor datapath. It sequences
//   the initial seed load, N_ITER hyperbolic iterations and a final Z-adder
//   pass that forms exp(T) = cosh(T) + sinh(T) in the result register. Towards
//   the host it provides a start/ready/ack handshake. It also keeps sticky
//   overflow and ack-timeout flags.
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   BEG_FSM_CORDIC            host start request (level, sampled in IDLE only)
//   ACK_FSM_CORDIC            host acknowledge, releases READY_CORDIC
//   ACK_SUMX/Y/Z              adder done strobes from the datapath
//   O_FX/Y/Z, U_FX/Y/Z        adder overflow/underflow, sampled with the ACK
//   CONT_ITERA                datapath iteration counter value
//   RST_EX                    datapath reset (reset and INIT)
//   MS_1, MS_2                REG1 source select, Z-adder operand select
//   EN_REG1X/Y/Z, EN_REG2XYZ,
//   EN_REG2, EN_REG3          datapath register enables
//   ADD_SUBT                  adder operation, tied to add
//   BEGIN_SUMX/Y/Z            adder start pulses
//   CLK_CDIR                  iteration counter increment pulse
//   READY_CORDIC              result valid until host ack
//   ERR_OVF, ERR_TMO          sticky error flags, cleared on the next start
//
// state  | meaning
// IDLE   | waiting for BEG_FSM_CORDIC
// INIT   | datapath reset pulse
// LOAD   | seed/T loaded into REG1
// SAVE   | previous values saved, multiply wait armed
// MULW   | waiting MUL_LAT cycles for the shift multiply
// SHREG  | shifted operand captured
// ADDS   | X/Y/Z adders started
// ADDW   | collecting the three adder acks
// UPD    | adder results into REG1, iteration counter stepped
// FADD   | operands for the final sum captured
// FBEG   | final Z-adder started
// FWAIT  | waiting for the final Z-adder ack
// STORE  | result register loaded
// DONE   | result valid, waiting for host ack

module cordic_exp_ctrl #(
    parameter int D       = 5,
    parameter int N_ITER  = 24,
    parameter int MUL_LAT = 2,
    parameter int TMO     = 63
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         BEG_FSM_CORDIC,
    input  logic         ACK_FSM_CORDIC,
    input  logic         ACK_SUMX,
    input  logic         ACK_SUMY,
    input  logic         ACK_SUMZ,
    input  logic         O_FX,
    input  logic         O_FY,
    input  logic         O_FZ,
    input  logic         U_FX,
    input  logic         U_FY,
    input  logic         U_FZ,
    input  logic [D-1:0] CONT_ITERA,
    output logic         RST_EX,
    output logic         MS_1,
    output logic         EN_REG1X,
    output logic         EN_REG1Y,
    output logic         EN_REG1Z,
    output logic         EN_REG2XYZ,
    output logic         EN_REG2,
    output logic         MS_2,
    output logic         ADD_SUBT,
    output logic         BEGIN_SUMX,
    output logic         BEGIN_SUMY,
    output logic         BEGIN_SUMZ,
    output logic         CLK_CDIR,
    output logic         EN_REG3,
    output logic         READY_CORDIC,
    output logic         ERR_OVF,
    output logic         ERR_TMO
);

    localparam int TW = $clog2(TMO + 1);
    localparam int MW = $clog2(MUL_LAT + 1);
    localparam logic [D-1:0]  LAST_ITER = D'(N_ITER - 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TMO);
    localparam logic [MW-1:0] MUL_LOAD  = MW'(MUL_LAT);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_LOAD, S_SAVE, S_MULW, S_SHREG, S_ADDS,
        S_ADDW, S_UPD, S_FADD, S_FBEG, S_FWAIT, S_STORE, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [MW-1:0] wait_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    ack_seen;
    logic [2:0]    ack_now;
    logic          acks_all;
    logic          tmo_last;
    logic          wait_last;
    logic          ovf_new;

    // Signs travel in the operands, so the adders always add.
    assign ADD_SUBT = 1'b0;

    always_comb begin
        ack_now   = {ACK_SUMZ, ACK_SUMY, ACK_SUMX};
        // An ack arriving on the cycle that completes the set counts now,
        // so ADDW lasts exactly as long as the slowest adder.
        acks_all  = &(ack_seen | ack_now);
        tmo_last  = (tmo_cnt == TW'(1));
        wait_last = (wait_cnt == MW'(1));
        // Flags are only taken from the first ack of each adder.
        ovf_new   = (ACK_SUMX & ~ack_seen[0] & (O_FX | U_FX))
                  | (ACK_SUMY & ~ack_seen[1] & (O_FY | U_FY))
                  | (ACK_SUMZ & ~ack_seen[2] & (O_FZ | U_FZ));

        state_nxt = state;
        case (state)
            S_IDLE:  if (BEG_FSM_CORDIC) state_nxt = S_INIT;
            S_INIT:  state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SAVE;
            S_SAVE:  state_nxt = S_MULW;
            S_MULW:  if (wait_last) state_nxt = S_SHREG;
            S_SHREG: state_nxt = S_ADDS;
            S_ADDS:  state_nxt = S_ADDW;
            S_ADDW: begin
                if (acks_all)      state_nxt = S_UPD;
                else if (tmo_last) state_nxt = S_IDLE;
            end
            S_UPD:   state_nxt = (CONT_ITERA == LAST_ITER) ? S_FADD : S_SAVE;
            S_FADD:  state_nxt = S_FBEG;
            S_FBEG:  state_nxt = S_FWAIT;
            S_FWAIT: begin
                if (ACK_SUMZ)      state_nxt = S_STORE;
                else if (tmo_last) state_nxt = S_IDLE;
            end
            S_STORE: state_nxt = S_DONE;
            S_DONE:  if (ACK_FSM_CORDIC) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            tmo_cnt      <= '0;
            ack_seen     <= '0;
            ERR_OVF      <= 1'b0;
            ERR_TMO      <= 1'b0;
            RST_EX       <= 1'b1;
            MS_1         <= 1'b0;
            EN_REG1X     <= 1'b0;
            EN_REG1Y     <= 1'b0;
            EN_REG1Z     <= 1'b0;
            EN_REG2XYZ   <= 1'b0;
            EN_REG2      <= 1'b0;
            MS_2         <= 1'b0;
            BEGIN_SUMX   <= 1'b0;
            BEGIN_SUMY   <= 1'b0;
            BEGIN_SUMZ   <= 1'b0;
            CLK_CDIR     <= 1'b0;
            EN_REG3      <= 1'b0;
            READY_CORDIC <= 1'b0;
        end else begin
            state <= state_nxt;

            case (state)
                S_IDLE: begin
                    if (BEG_FSM_CORDIC) begin
                        ERR_OVF <= 1'b0;
                        ERR_TMO <= 1'b0;
                    end
                end
                S_SAVE: wait_cnt <= MUL_LOAD;
                S_MULW: wait_cnt <= wait_cnt - MW'(1);
                S_ADDS, S_FBEG: begin
                    ack_seen <= '0;
                    tmo_cnt  <= TMO_LOAD;
                end
                S_ADDW: begin
                    ack_seen <= ack_seen | ack_now;
                    tmo_cnt  <= tmo_cnt - TW'(1);
                    if (ovf_new) ERR_OVF <= 1'b1;
                    if (!acks_all && tmo_last) ERR_TMO <= 1'b1;
                end
                S_FWAIT: begin
                    tmo_cnt <= tmo_cnt - TW'(1);
                    if (ACK_SUMZ) begin
                        if (O_FZ | U_FZ) ERR_OVF <= 1'b1;
                    end else if (tmo_last) begin
                        ERR_TMO <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Outputs decoded from the state being entered, so each one is
            // valid for exactly the cycle the FSM spends in that state.
            RST_EX       <= (state_nxt == S_INIT);
            MS_1         <= (state_nxt == S_LOAD);
            EN_REG1X     <= (state_nxt == S_LOAD) || (state_nxt == S_UPD);
            EN_REG1Y     <= (state_nxt == S_LOAD) || (state_nxt == S_UPD);
            EN_REG1Z     <= (state_nxt == S_LOAD) || (state_nxt == S_UPD);
            EN_REG2XYZ   <= (state_nxt == S_SAVE) || (state_nxt == S_FADD);
            EN_REG2      <= (state_nxt == S_SHREG) || (state_nxt == S_FADD);
            MS_2         <= (state_nxt == S_FBEG) || (state_nxt == S_FWAIT)
                         || (state_nxt == S_STORE);
            BEGIN_SUMX   <= (state_nxt == S_ADDS);
            BEGIN_SUMY   <= (state_nxt == S_ADDS);
            BEGIN_SUMZ   <= (state_nxt == S_ADDS) || (state_nxt == S_FBEG);
            CLK_CDIR     <= (state_nxt == S_UPD);
            EN_REG3      <= (state_nxt == S_STORE);
            READY_CORDIC <= (state_nxt == S_DONE);
        end
    end

endmodule
